// File: rtl/alu_req_arbiter.sv
// ---------------------------------------------------------------------------
// alu_req_arbiter
//
// Shares one multi-cycle ALU between two requesters. An IDLE-state
// round-robin grant accepts one request. Its opcode and operands are
// registered onto the ALU inputs. After ALU_LAT edges the ALU result and
// status are captured and returned to the owning requester. Statuses that
// carry the error flag (bit 3) are tallied in a saturating 8-bit counter.
//
// Handshakes (both directions): a transfer happens on a rising i_clk edge
// where valid and ready are both high. A requester keeps valid and payload
// stable until the transfer. Ready may depend combinationally on valid.
// Valid never depends on ready.
//
// Ports
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_req_valid/o_req_ready   per-requester request handshake (bit r = req r)
//   i_req_op/arg_A/arg_B      packed request payloads, requester r at [r*W +: W]
//   o_rsp_valid/i_rsp_ready   per-requester response handshake
//   o_rsp_result/o_rsp_status captured ALU outputs (shared by both requesters)
//   o_alu_op/arg_A/arg_B      registered ALU operand drive
//   i_alu_result/i_alu_status ALU outputs
//   o_busy                    high in any state other than IDLE
//   o_err_count               saturating count of error statuses
//   o_state                   FSM state (0 IDLE, 1 WAIT, 2 RESP) for observation
// ---------------------------------------------------------------------------
module alu_req_arbiter #(
  parameter int N       = 2,
  parameter int M       = 4,
  parameter int ALU_LAT = 1
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic [1:0]     i_req_valid,
  input  logic [2*N-1:0] i_req_op,
  input  logic [2*M-1:0] i_req_arg_A,
  input  logic [2*M-1:0] i_req_arg_B,
  output logic [1:0]     o_req_ready,
  output logic [1:0]     o_rsp_valid,
  input  logic [1:0]     i_rsp_ready,
  output logic [M-1:0]   o_rsp_result,
  output logic [3:0]     o_rsp_status,
  output logic [N-1:0]   o_alu_op,
  output logic [M-1:0]   o_alu_arg_A,
  output logic [M-1:0]   o_alu_arg_B,
  input  logic [M-1:0]   i_alu_result,
  input  logic [3:0]     i_alu_status,
  output logic           o_busy,
  output logic [7:0]     o_err_count,
  output logic [1:0]     o_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

  state_t     state;
  state_t     state_nxt;
  logic       p;        // round-robin pointer: preferred requester
  logic       own;      // requester that owns the in-flight operation
  logic [2:0] cnt;      // remaining ALU latency edges

  logic any_req;
  logic g;              // granted requester when any_req is high
  logic accept;
  logic rsp_take;

  // The pointer only breaks ties. A lone valid requester always wins.
  assign any_req  = |i_req_valid;
  assign g        = i_req_valid[p] ? p : ~p;
  // The reset gate keeps ready low while reset is held, even with valid high.
  assign accept   = (state == S_IDLE) && any_req && !i_reset;
  assign rsp_take = (state == S_RESP) && i_rsp_ready[own];

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= S_IDLE;
      p            <= 1'b0;
      own          <= 1'b0;
      cnt          <= 3'd0;
      o_alu_op     <= '0;
      o_alu_arg_A  <= '0;
      o_alu_arg_B  <= '0;
      o_rsp_result <= '0;
      o_rsp_status <= '0;
      o_err_count  <= 8'd0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (accept) begin
            // The operands stay put until the next acceptance, so the ALU
            // never sees them change mid-operation.
            o_alu_op    <= g ? i_req_op[N +: N]    : i_req_op[0 +: N];
            o_alu_arg_A <= g ? i_req_arg_A[M +: M] : i_req_arg_A[0 +: M];
            o_alu_arg_B <= g ? i_req_arg_B[M +: M] : i_req_arg_B[0 +: M];
            own         <= g;
            cnt         <= LAT_INIT;
          end
        end
        S_WAIT: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            o_rsp_result <= i_alu_result;
            o_rsp_status <= i_alu_status;
            if (i_alu_status[3] && (o_err_count != 8'hFF)) begin
              o_err_count <= o_err_count + 8'd1;
            end
          end
        end
        S_RESP: begin
          if (rsp_take) begin
            p <= ~own;
          end
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)        state_nxt = S_WAIT;
      S_WAIT:  if (cnt == 3'd0)   state_nxt = S_RESP;
      S_RESP:  if (rsp_take)      state_nxt = S_IDLE;
      default:                    state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    o_req_ready = 2'b00;
    o_rsp_valid = 2'b00;
    if (accept) begin
      o_req_ready[g] = 1'b1;
    end
    if (state == S_RESP) begin
      o_rsp_valid[own] = 1'b1;
    end
  end

  assign o_busy  = (state != S_IDLE);
  assign o_state = state;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_req_arbiter
//
// Directed bench for alu_req_arbiter with ALU_LAT = 1. A small registered
// ALU stand-in sits on the o_alu_* / i_alu_* ports. It gives one cycle of
// latency. Its results and statuses are fixed by f_res / f_stat below. The
// force_err input can force status bit 3 high.
// Inputs are driven 1 time unit after a rising edge. Outputs are sampled on
// falling edges. A scoreboard pairs every accepted request with the
// response it should produce.
// ---------------------------------------------------------------------------
module tb_alu_req_arbiter;

  localparam int N   = 2;
  localparam int M   = 4;
  localparam int LAT = 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [1:0]   req_valid;
  logic [2*N-1:0] req_op;
  logic [2*M-1:0] req_a;
  logic [2*M-1:0] req_b;
  logic [1:0]   req_ready;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [M-1:0] rsp_result;
  logic [3:0]   rsp_status;
  logic [N-1:0] alu_op;
  logic [M-1:0] alu_a;
  logic [M-1:0] alu_b;
  logic [M-1:0] alu_result = '0;
  logic [3:0]   alu_status = '0;
  logic         busy;
  logic [7:0]   err_count;
  logic [1:0]   dbg_state;
  logic         force_err = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [8:0] exp_q[$];   // {requester, status, result}
  int         g_q[$];     // granted requester per acceptance
  int         t_q[$];     // cycle of each acceptance

  alu_req_arbiter #(.N(N), .M(M), .ALU_LAT(LAT)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_req_valid  (req_valid),
    .i_req_op     (req_op),
    .i_req_arg_A  (req_a),
    .i_req_arg_B  (req_b),
    .o_req_ready  (req_ready),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_result (rsp_result),
    .o_rsp_status (rsp_status),
    .o_alu_op     (alu_op),
    .o_alu_arg_A  (alu_a),
    .o_alu_arg_B  (alu_b),
    .i_alu_result (alu_result),
    .i_alu_status (alu_status),
    .o_busy       (busy),
    .o_err_count  (err_count),
    .o_state      (dbg_state)
  );

  // ALU stand-in
  function automatic logic [3:0] f_res(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      2'b00:   return a - b;
      2'b01:   return a & b;
      2'b10:   return a + b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [3:0] f_stat(input logic [1:0] op);
    return {op == 2'b00, op == 2'b10, 1'b0, op == 2'b00};
  endfunction

  always @(posedge clk) begin
    alu_result <= f_res(alu_op, alu_a, alu_b);
    alu_status <= f_stat(alu_op) | {force_err, 3'b000};
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard: expectation pushed at acceptance, compared at consumption
  always @(negedge clk) begin : sb
    int r;
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    if (!rst && ((req_valid & req_ready) != 2'b00)) begin
      r  = req_ready[1] ? 1 : 0;
      op = req_op[r*2 +: 2];
      a  = req_a[r*4 +: 4];
      b  = req_b[r*4 +: 4];
      exp_q.push_back({r[0], f_stat(op) | {force_err, 3'b000}, f_res(op, a, b)});
      g_q.push_back(r);
      t_q.push_back(cyc);
    end
    if ((rsp_valid & rsp_ready) != 2'b00) begin
      check("rsp_onehot", 32'(rsp_valid != 2'b11), 32'd1);
      if (exp_q.size() == 0) begin
        check("sb_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        check("sb_rsp", 32'({rsp_valid[1], rsp_status, rsp_result}), 32'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic issue(input int r, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int k;
    @(posedge clk); #1;
    req_op[r*2 +: 2] = op;
    req_a[r*4 +: 4]  = a;
    req_b[r*4 +: 4]  = b;
    req_valid[r]     = 1'b1;
    k = 0;
    @(negedge clk);
    while (!req_ready[r] && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("req_ready", 32'(req_ready[r]), 32'd1);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  // Called 1 unit after the acceptance edge. The response is due on the
  // (LAT+2)-th falling edge.
  task automatic wait_rsp(input int r);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rsp_valid[r] && k < 50);
    check("rsp_latency", 32'(k), 32'(LAT + 2));
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("sb_drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int k;
    logic [1:0] seen;

    // reset state, with both requests valid during reset
    rst       = 1'b1;
    req_valid = 2'b11;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 2'b11;
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_alu", 32'({alu_op, alu_a, alu_b}), 32'd0);
    check("rst_rsp_data", 32'({rsp_result, rsp_status}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;

    // single request from requester 0: 2 + 3
    issue(0, 2'b10, 4'b0010, 4'b0011);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_alu", 32'({alu_op, alu_a, alu_b}), 32'({2'b10, 4'b0010, 4'b0011}));
    wait_rsp(0);
    check("t1_rsp_valid", 32'(rsp_valid), 32'b01);
    check("t1_result", 32'(rsp_result), 32'b0101);
    check("t1_status", 32'(rsp_status), 32'b0100);
    check("t1_err", 32'(err_count), 32'd0);
    @(negedge clk);
    check("t1_busy_fall", 32'(busy), 32'd0);
    check("t1_rsp_done", 32'(rsp_valid), 32'd0);

    // error status from requester 1
    issue(1, 2'b00, 4'b1101, 4'b0011);
    wait_rsp(1);
    check("t2_rsp_valid", 32'(rsp_valid), 32'b10);
    check("t2_status", 32'(rsp_status), 32'b1001);
    check("t2_err", 32'(err_count), 32'd1);

    // contention: both valid, expect grants 0,1,0,1 spaced 4 cycles
    g_q.delete();
    t_q.delete();
    @(posedge clk); #1;
    req_op    = {2'b11, 2'b10};
    req_a     = {4'd5, 4'd1};
    req_b     = {4'd3, 4'd1};
    req_valid = 2'b11;
    k = 0;
    while (g_q.size() < 4 && k < 60) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();
    check("t3_grant_count", 32'(g_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t3_grant_order", 32'(i < g_q.size() ? g_q[i] : 99), 32'(i % 2));
    end
    for (int i = 1; i < 4; i++) begin
      check("t3_spacing", 32'(i < t_q.size() ? t_q[i] - t_q[i-1] : 0), 32'(LAT + 3));
    end

    // response back-pressure with requester 1 waiting
    rsp_ready = 2'b00;
    issue(0, 2'b01, 4'hC, 4'hA);
    wait_rsp(0);
    @(posedge clk); #1;
    req_op[3:2]  = 2'b11;
    req_a[7:4]   = 4'd6;
    req_b[7:4]   = 4'd3;
    req_valid[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold", 32'({rsp_valid, rsp_result, rsp_status, req_ready}), 32'({2'b01, 4'h8, 4'h0, 2'b00}));
    end
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    @(posedge clk);
    @(negedge clk);
    check("t4_first_idle_grant", 32'(req_ready), 32'b10);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_rsp(1);
    check("t4_result", 32'(rsp_result), 32'd5);
    drain();

    // reset mid-operation: make p = 1, then reset while requester 1 is in WAIT
    issue(0, 2'b10, 4'd1, 4'd2);
    wait_rsp(0);
    issue(1, 2'b10, 4'd3, 4'd4);
    check("t5_in_wait", 32'(dbg_state), 32'd1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("t5_async_outputs", 32'({req_ready, rsp_valid, busy, err_count}), 32'd0);
    check("t5_async_data", 32'({alu_op, alu_a, alu_b, rsp_result, rsp_status}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 2'b00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    check("t5_no_rsp", 32'(seen), 32'd0);
    @(posedge clk); #1;
    req_op    = {2'b01, 2'b10};
    req_a     = {4'd7, 4'd4};
    req_b     = {4'd7, 4'd4};
    req_valid = 2'b11;
    @(negedge clk);
    check("t5_ptr_reset", 32'(req_ready), 32'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_rsp(0);
    check("t5_result", 32'(rsp_result), 32'd8);
    check("t5_err", 32'(err_count), 32'd0);
    drain();

    // saturation of the error counter
    force_err = 1'b1;
    for (int i = 0; i < 260; i++) begin
      issue(0, 2'b10, 4'd1, 4'd1);
      wait_rsp(0);
      if (i == 0)   check("t6_err_first", 32'(err_count), 32'd1);
      if (i == 254) check("t6_err_255", 32'(err_count), 32'd255);
    end
    check("t6_err_sat", 32'(err_count), 32'd255);
    drain();
    force_err = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Two-port round-robin arbiter and sequencer that shares one `sync_arith_unit_4` instance between two requesters. It accepts operation requests over a valid/ready handshake and drives the ALU operands from registers. It waits a fixed ALU latency, captures `o_result`/`o_status`, and returns them to the owning requester over a second valid/ready handshake. It also keeps a saturating count of operations whose status reports an error (status bit 3).

## Interface
Parameters:
- `N`, 2, opcode width (matches ALU `N`)
- `M`, 4, operand/result width (matches ALU `M`)
- `ALU_LAT`, 1, ALU clock edges from operand change to valid result; range 1..7

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge
- `i_reset`  in  1  asynchronous, active-high reset
- `i_req_valid`  in  2  per-requester request valid; bit r = requester r
- `i_req_op`  in  2*N  opcodes, requester r in bits [r*N +: N]
- `i_req_arg_A`  in  2*M  operand A, requester r in bits [r*M +: M]
- `i_req_arg_B`  in  2*M  operand B, same packing as A
- `o_req_ready`  out  2  request accepted when valid & ready at a rising edge
- `o_rsp_valid`  out  2  response valid; at most one bit high
- `i_rsp_ready`  in  2  response consumed when valid & ready at a rising edge
- `o_rsp_result`  out  M  captured ALU result (shared by both requesters)
- `o_rsp_status`  out  4  captured ALU status (shared)
- `o_alu_op`  out  N  to ALU `i_op`
- `o_alu_arg_A`  out  M  to ALU `i_arg_A`
- `o_alu_arg_B`  out  M  to ALU `i_arg_B`
- `i_alu_result`  in  M  from ALU `o_result`
- `i_alu_status`  in  4  from ALU `o_status`
- `o_busy`  out  1  high in any state other than IDLE
- `o_err_count`  out  8  saturating count of captured statuses with bit 3 = 1

## Operation
- State machine states: IDLE, WAIT, RESP.
- Registered state: round-robin pointer `p` (1 bit), owner `own` (1 bit), latency counter `cnt` (3 bits).
- **IDLE**
  - Grant `g` = `p` if `i_req_valid[p]`, otherwise `~p` if `i_req_valid[~p]`, otherwise none.
  - `o_req_ready[g]` = 1, combinational; the other bit is 0. With no valid request, `o_req_ready` = 0.
  - On acceptance:
    - Register op/A/B of requester `g` into `o_alu_*`.
    - `own` <= `g`, `cnt` <= `ALU_LAT`, state <= WAIT.
- **WAIT**
  - `o_req_ready` = 0.
  - If `cnt` != 0: `cnt` <= `cnt`-1.
  - If `cnt` = 0:
    - Capture `i_alu_result` into `o_rsp_result` and `i_alu_status` into `o_rsp_status`.
    - If `i_alu_status[3]` = 1 and `o_err_count` < 255, increment `o_err_count`.
    - State <= RESP.
- **RESP**
  - `o_rsp_valid[own]` = 1.
  - On `i_rsp_ready[own]`: state <= IDLE, `p` <= `~own`.
  - `i_rsp_ready[~own]` is ignored.
- Width and hold rules:
  - `o_alu_*` hold their value from acceptance until the next acceptance.
  - The ALU never sees operand changes mid-operation.
  - Opcode, operands, result and status pass through bit-exact; no arithmetic is done here.
  - `o_rsp_result` and `o_rsp_status` are stable while any `o_rsp_valid` bit is high.
- Requester rules:
  - A requester may drop valid before acceptance; this has no effect.
  - The payload must be stable while valid is high.
  - A request arriving during WAIT/RESP waits; it is not lost.
- Fairness:
  - When both requesters are continuously valid, grants alternate 0,1,0,1…
  - A single active requester is granted every operation.

## Timing
- Reset values (asynchronous, while `i_reset` = 1):
  - state IDLE, `p` = 0, `own` = 0, `cnt` = 0.
  - `o_alu_op`/`o_alu_arg_A`/`o_alu_arg_B` = 0.
  - `o_rsp_result` = 0, `o_rsp_status` = 0, `o_rsp_valid` = 0, `o_err_count` = 0, `o_busy` = 0.
  - `o_req_ready` = 0 while reset is asserted.
- Reset mid-operation aborts the in-flight operation. No response is issued and the error count is cleared.
- Latency, with acceptance at edge E0:
  - `o_alu_*` are valid after E0.
  - Capture happens at edge E0+`ALU_LAT`+1.
  - `o_rsp_valid` rises after that edge.
  - With `ALU_LAT` = 1, the response is visible 2 cycles after acceptance.
- Throughput: with immediate `i_rsp_ready`, the minimum is one operation per `ALU_LAT`+3 cycles.
- `o_busy` rises the cycle after acceptance and falls the cycle after response consumption.
- A response held by low `i_rsp_ready` stalls indefinitely. No timeout.
- Simultaneous `i_req_valid` = 2'b11 in IDLE: pointer decides; no combinational path from `i_req_valid[r]` to `o_req_ready[~r]` beyond the grant logic.

## Test plan
- Reset then single request:
  - Stimulus: requester 0 sends op=2'b10, A=4'b0010, B=4'b0011; `ALU_LAT`=1, real ALU attached.
  - Required: `o_req_ready[0]` high in the same cycle; `o_rsp_valid` = 2'b01 2 cycles after acceptance; result 4'b0101, status 4'b0100; `o_err_count` = 0.
- Error status:
  - Stimulus: requester 1 sends op=2'b00, A=4'b1101, B=4'b0011.
  - Required: `o_rsp_valid` = 2'b10, status 4'b1001, `o_err_count` increments to 1; result not checked.
- Contention:
  - Stimulus: both requesters hold valid for 4 operations, `i_rsp_ready` = 2'b11.
  - Required: grants in order 0,1,0,1; each response routed to the correct bit; operation spacing exactly `ALU_LAT`+3 = 4 cycles.
- Response back-pressure:
  - Stimulus: hold `i_rsp_ready` = 0 for 5 cycles, with requester 1 valid meanwhile.
  - Required: `o_rsp_valid`/result/status stable; `o_req_ready` = 2'b00 until consumption; requester 1 is granted in the first IDLE cycle after.
- Reset mid-operation:
  - Stimulus: assert `i_reset` in WAIT.
  - Required: all outputs 0 immediately (asynchronous); no response after release; next request is handled normally starting with `p` = 0.
- Saturation:
  - Stimulus: force `i_alu_status[3]` = 1 for 260 operations.
  - Required: `o_err_count` stops at 255.
